// File: rtl/wb_pkg.sv
// Shared types and default sizes for the write-back queue.
package wb_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // One queue slot. Field widths come from the package defaults, so the
  // queue's DATA_W/ADDR_W parameters must be kept equal to these.
  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] reg_sel;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the occupied part of the write-back queue.
// Slots are walked from head (oldest) towards tail (youngest); a later hit
// overrides an earlier one, so the result is the youngest queued value.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wb_entry_t         entries_i [DEPTH],
  input  logic [PTR_W-1:0]  head_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [ADDR_W-1:0] sel_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic [PTR_W-1:0] idx;

  // Priority search: oldest first, youngest match is the last one written.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if ((CNT_W'(k) < count_i) && entries_i[idx].valid &&
          (entries_i[idx].reg_sel == sel_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue in front of the register file. Buffers ALU and memory
// results in order, drains the head into the single rf write port every
// cycle, and offers two forwarding lookups over the queued results.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              mem_valid_i,
  input  logic [ADDR_W-1:0] mem_reg_sel_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_ready_o,

  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_reg_sel_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,

  output logic              write_enable_o,
  output logic [ADDR_W-1:0] write_reg_sel_o,
  output logic [DATA_W-1:0] write_data_o,

  input  logic [ADDR_W-1:0] read_reg1_sel_i,
  input  logic [ADDR_W-1:0] read_reg2_sel_i,
  output logic              fwd1_valid_o,
  output logic [DATA_W-1:0] fwd1_data_o,
  output logic              fwd2_valid_o,
  output logic [DATA_W-1:0] fwd2_data_o,

  output logic [CNT_W-1:0]  count_o
);

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             mem_push;
  logic             alu_push;
  logic             pop;
  logic [PTR_W-1:0] alu_slot;

  // Readiness looks only at the registered count; a same-cycle pop earns
  // no credit, which keeps the ready path short and never overfills.
  always_comb begin
    mem_ready_o = (count_q < CNT_W'(DEPTH));
    alu_ready_o = (count_q <= CNT_W'(DEPTH - 2)) ||
                  ((count_q == CNT_W'(DEPTH - 1)) && !mem_valid_i);
  end

  // Handshakes, pointer and count next-state. Mem is always the older
  // entry when both producers land in the same cycle.
  always_comb begin
    mem_push = mem_valid_i && mem_ready_o;
    alu_push = alu_valid_i && alu_ready_o;
    pop      = (count_q != '0);
    alu_slot = tail_q + PTR_W'(mem_push);
    head_d   = head_q + PTR_W'(pop);
    tail_d   = tail_q + PTR_W'(mem_push) + PTR_W'(alu_push);
    count_d  = count_q + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
  end

  // Head entry drives the rf write port; a reset cycle discards the pop,
  // so the write is suppressed there as well.
  always_comb begin
    write_enable_o  = pop && !rst_i;
    write_reg_sel_o = '0;
    write_data_o    = '0;
    if (write_enable_o) begin
      write_reg_sel_o = entries_q[head_q].reg_sel;
      write_data_o    = entries_q[head_q].data;
    end
  end

  // Queue state update; pushes are applied after the pop so a slot freed
  // and refilled in one cycle ends up holding the new entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop) begin
        entries_q[head_q].valid <= 1'b0;
      end
      if (mem_push) begin
        entries_q[tail_q] <= '{valid: 1'b1, reg_sel: mem_reg_sel_i, data: mem_data_i};
      end
      if (alu_push) begin
        entries_q[alu_slot] <= '{valid: 1'b1, reg_sel: alu_reg_sel_i, data: alu_data_i};
      end
    end
  end

  assign count_o = count_q;

  wb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd1 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .sel_i     (read_reg1_sel_i),
    .hit_o     (fwd1_valid_o),
    .data_o    (fwd1_data_o)
  );

  wb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd2 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .sel_i     (read_reg2_sel_i),
    .hit_o     (fwd2_valid_o),
    .data_o    (fwd2_data_o)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed and random checks of wb_queue against a queue-based reference.
module tb_wb_queue;

  logic        clk_sys = 1'b0;
  logic        rst_i;
  logic        mem_valid_i, alu_valid_i;
  logic [4:0]  mem_reg_sel_i, alu_reg_sel_i;
  logic [31:0] mem_data_i, alu_data_i;
  logic        mem_ready_o, alu_ready_o;
  logic        write_enable_o;
  logic [4:0]  write_reg_sel_o;
  logic [31:0] write_data_o;
  logic [4:0]  read_reg1_sel_i, read_reg2_sel_i;
  logic        fwd1_valid_o, fwd2_valid_o;
  logic [31:0] fwd1_data_o, fwd2_data_o;
  logic [2:0]  count_o;

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] rf_q [32];
  int          n_writes = 0;
  int          n_chk    = 0;
  int          n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  wb_queue dut (
    .clk_i           (clk_sys),
    .rst_i           (rst_i),
    .mem_valid_i     (mem_valid_i),
    .mem_reg_sel_i   (mem_reg_sel_i),
    .mem_data_i      (mem_data_i),
    .mem_ready_o     (mem_ready_o),
    .alu_valid_i     (alu_valid_i),
    .alu_reg_sel_i   (alu_reg_sel_i),
    .alu_data_i      (alu_data_i),
    .alu_ready_o     (alu_ready_o),
    .write_enable_o  (write_enable_o),
    .write_reg_sel_o (write_reg_sel_o),
    .write_data_o    (write_data_o),
    .read_reg1_sel_i (read_reg1_sel_i),
    .read_reg2_sel_i (read_reg2_sel_i),
    .fwd1_valid_o    (fwd1_valid_o),
    .fwd1_data_o     (fwd1_data_o),
    .fwd2_valid_o    (fwd2_valid_o),
    .fwd2_data_o     (fwd2_data_o),
    .count_o         (count_o)
  );

  // Register file as seen through the write port.
  always @(posedge clk_sys) begin
    if (write_enable_o) begin
      rf_q[write_reg_sel_o] <= write_data_o;
      n_writes <= n_writes + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check every output against the model, clock, update model.
  task automatic cycle(input logic rst, input logic mv, input logic [4:0] ms,
                       input logic [31:0] md, input logic av, input logic [4:0] as,
                       input logic [31:0] ad, input logic [4:0] r1, input logic [4:0] r2);
    int   mcount;
    logic emr, ear, f1v, f2v;
    logic [31:0] f1d, f2d;
    rst_i = rst; mem_valid_i = mv; mem_reg_sel_i = ms; mem_data_i = md;
    alu_valid_i = av; alu_reg_sel_i = as; alu_data_i = ad;
    read_reg1_sel_i = r1; read_reg2_sel_i = r2;
    #1;
    mcount = exp_q.size();
    emr = (mcount < 4);
    ear = (mcount <= 2) || (mcount == 3 && !mv);
    chk("count", 32'(count_o), 32'(mcount));
    chk("mem_ready", 32'(mem_ready_o), 32'(emr));
    chk("alu_ready", 32'(alu_ready_o), 32'(ear));
    if (!rst && mcount != 0) begin
      chk("we", 32'(write_enable_o), 32'd1);
      chk("wsel", 32'(write_reg_sel_o), 32'(exp_q[0].sel));
      chk("wdata", write_data_o, exp_q[0].data);
    end else begin
      chk("we_idle", 32'(write_enable_o), 32'd0);
    end
    f1v = 1'b0; f1d = '0; f2v = 1'b0; f2d = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].sel == r1) begin f1v = 1'b1; f1d = exp_q[i].data; end
      if (exp_q[i].sel == r2) begin f2v = 1'b1; f2d = exp_q[i].data; end
    end
    chk("fwd1_v", 32'(fwd1_valid_o), 32'(f1v));
    chk("fwd1_d", fwd1_data_o, f1d);
    chk("fwd2_v", 32'(fwd2_valid_o), 32'(f2v));
    chk("fwd2_d", fwd2_data_o, f2d);
    @(posedge clk_sys);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (mcount != 0) void'(exp_q.pop_front());
      if (mv && emr) exp_q.push_back('{sel: ms, data: md});
      if (av && ear) exp_q.push_back('{sel: as, data: ad});
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  initial begin
    int w0;
    rst_i = 1'b1; mem_valid_i = 1'b0; alu_valid_i = 1'b0;
    mem_reg_sel_i = '0; alu_reg_sel_i = '0; mem_data_i = '0; alu_data_i = '0;
    read_reg1_sel_i = '0; read_reg2_sel_i = '0;
    repeat (2) @(posedge clk_sys);
    #1;

    // Reset state
    idle(5'd7, 5'd0);

    // Single push, one-cycle latency into rf
    cycle(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    chk("single_we", 32'(write_enable_o), 32'd1);
    chk("single_sel", 32'(write_reg_sel_o), 32'd7);
    chk("single_data", write_data_o, 32'hDEADBEEF);
    idle(5'd7, 5'd0);
    chk("single_cnt0", 32'(count_o), 32'd0);
    chk("single_rf7", rf_q[7], 32'hDEADBEEF);

    // Dual push: mem older than alu
    cycle(1'b0, 1'b1, 5'd3, 32'h11111111, 1'b1, 5'd4, 32'h22222222, 5'd3, 5'd4);
    chk("dual_cnt2", 32'(count_o), 32'd2);
    chk("dual_sel3", 32'(write_reg_sel_o), 32'd3);
    idle(5'd3, 5'd4);
    chk("dual_cnt1", 32'(count_o), 32'd1);
    chk("dual_sel4", 32'(write_reg_sel_o), 32'd4);
    idle(5'd3, 5'd4);
    chk("dual_cnt0", 32'(count_o), 32'd0);
    chk("dual_rf3", rf_q[3], 32'h11111111);
    chk("dual_rf4", rf_q[4], 32'h22222222);

    // Same register twice: youngest forwarded and finally written
    cycle(1'b0, 1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB, 5'd9, 5'd1);
    chk("fwd_young_v", 32'(fwd1_valid_o), 32'd1);
    chk("fwd_young_d", fwd1_data_o, 32'hB);
    idle(5'd9, 5'd1);
    idle(5'd9, 5'd1);
    chk("fwd_drained", 32'(fwd1_valid_o), 32'd0);
    chk("fwd_rf9", rf_q[9], 32'hB);

    // Backpressure at count 3
    cycle(1'b0, 1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101, 5'd10, 5'd11);
    cycle(1'b0, 1'b1, 5'd12, 32'h102, 1'b1, 5'd13, 32'h103, 5'd12, 5'd13);
    chk("bp_cnt3", 32'(count_o), 32'd3);
    cycle(1'b0, 1'b1, 5'd14, 32'h104, 1'b1, 5'd15, 32'h105, 5'd14, 5'd15);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'h106, 5'd16, 5'd15);
    repeat (4) idle(5'd14, 5'd16);
    chk("bp_rf15_untouched", 32'(rf_q[15] == 32'h105), 32'd0);
    chk("bp_rf16", rf_q[16], 32'h106);

    // Random traffic with wrap-around
    for (int i = 0; i < 500; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
      chk("cnt_le4", 32'(count_o <= 3'd4), 32'd1);
    end
    repeat (5) idle(5'd0, 5'd1);

    // Reset while entries are queued
    cycle(1'b0, 1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h201, 5'd20, 5'd21);
    cycle(1'b0, 1'b1, 5'd22, 32'h202, 1'b1, 5'd23, 32'h203, 5'd22, 5'd23);
    chk("rst_pre_cnt3", 32'(count_o), 32'd3);
    w0 = n_writes;
    cycle(1'b1, 1'b1, 5'd24, 32'h204, 1'b0, 5'd0, 32'd0, 5'd22, 5'd23);
    chk("rst_we0", 32'(write_enable_o), 32'd0);
    chk("rst_cnt0", 32'(count_o), 32'd0);
    chk("rst_fwd1", 32'(fwd1_valid_o), 32'd0);
    chk("rst_fwd2", 32'(fwd2_valid_o), 32'd0);
    repeat (3) idle(5'd22, 5'd24);
    chk("rst_no_writes", 32'(n_writes - w0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
